// File: rtl/traffic_generator_ctrl.sv
// traffic_generator_ctrl
// Run-control sequencer between the CPU register block and the packet
// generation engine. Launches one packet at a time with a programmable
// inter-packet gap, counts completed packets and reports busy/done/error.
// All outputs are registered.
//
// Optional build macro: TRAFFIC_GENERATOR_CTRL_LEN_SWEEP_EN
//   adds cfg_pkt_len_max and sweeps the packet length from cfg_pkt_len up to
//   cfg_pkt_len_max, wrapping back, one step per launch.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no run in progress; waiting for an accepted start
// LAUNCH    | gen_req asserted, waiting for the engine to take the packet
// WAIT_DONE | packet accepted, waiting for gen_done
// GAP       | counting idle cycles before the next launch

module traffic_generator_ctrl #(
    parameter int COUNT_WIDTH = 32,
    parameter int GAP_WIDTH   = 16,
    parameter int LEN_WIDTH   = 14,
    parameter int MIN_LEN     = 60
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    input  logic                   ctrl_start,
    input  logic                   ctrl_stop,
    input  logic [COUNT_WIDTH-1:0] cfg_pkt_count,
    input  logic [GAP_WIDTH-1:0]   cfg_gap,
    input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
`ifdef TRAFFIC_GENERATOR_CTRL_LEN_SWEEP_EN
    input  logic [LEN_WIDTH-1:0]   cfg_pkt_len_max,
`endif
    output logic                   gen_req,
    output logic [LEN_WIDTH-1:0]   gen_len,
    input  logic                   gen_ready,
    input  logic                   gen_done,
    output logic                   stat_busy,
    output logic                   stat_done,
    output logic                   stat_cfg_err,
    output logic [COUNT_WIDTH-1:0] stat_pkts_sent,
    input  logic                   stat_clear
);

    localparam logic [LEN_WIDTH-1:0]   MIN_LEN_V = LEN_WIDTH'(MIN_LEN);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0]   GAP_ONE   = GAP_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [GAP_WIDTH-1:0]   gap_cfg_q, gap_cfg_d;
    logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   stop_pending_q, stop_pending_d;
    logic                   gen_req_q, gen_req_d;
    logic [LEN_WIDTH-1:0]   gen_len_q, gen_len_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [COUNT_WIDTH-1:0] pkts_q, pkts_d;
`ifdef TRAFFIC_GENERATOR_CTRL_LEN_SWEEP_EN
    logic [LEN_WIDTH-1:0]   len_base_q, len_base_d;
    logic [LEN_WIDTH-1:0]   len_max_q, len_max_d;
`endif

    logic                   start_ok;
    logic                   start_bad;
    logic                   pkt_inc;
    logic                   done_set;
    logic                   launch_next;
    logic [COUNT_WIDTH-1:0] pkts_new;
    logic [LEN_WIDTH-1:0]   len_next;

    // A start coinciding with a stop is dropped entirely, including the length check.
    assign start_ok  = ctrl_start && !ctrl_stop && (cfg_pkt_len >= MIN_LEN_V);
    assign start_bad = ctrl_start && !ctrl_stop && (cfg_pkt_len <  MIN_LEN_V);

    // Count after a completed packet; a coincident clear restarts it at one.
    assign pkts_new = stat_clear         ? CNT_ONE :
                      (pkts_q == '1)     ? pkts_q  :
                                           pkts_q + CNT_ONE;

    // Length for the next launch within a run.
`ifdef TRAFFIC_GENERATOR_CTRL_LEN_SWEEP_EN
    always_comb begin
        if ((len_max_q <= len_base_q) || (gen_len_q >= len_max_q)) begin
            len_next = len_base_q;
        end else begin
            len_next = gen_len_q + LEN_WIDTH'(1);
        end
    end
`else
    assign len_next = gen_len_q;
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        gap_cfg_d      = gap_cfg_q;
        gap_cnt_d      = gap_cnt_q;
        stop_pending_d = stop_pending_q;
        gen_len_d      = gen_len_q;
        pkts_d         = pkts_q;
`ifdef TRAFFIC_GENERATOR_CTRL_LEN_SWEEP_EN
        len_base_d     = len_base_q;
        len_max_d      = len_max_q;
`endif
        pkt_inc        = 1'b0;
        done_set       = 1'b0;
        launch_next    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d        = ST_LAUNCH;
                    count_d        = cfg_pkt_count;
                    gap_cfg_d      = cfg_gap;
                    gen_len_d      = cfg_pkt_len;
                    stop_pending_d = 1'b0;
                    pkts_d         = '0;
`ifdef TRAFFIC_GENERATOR_CTRL_LEN_SWEEP_EN
                    len_base_d     = cfg_pkt_len;
                    len_max_d      = cfg_pkt_len_max;
`endif
                end
            end
            ST_LAUNCH: begin
                // Once the engine has taken the packet it must complete, so a
                // stop in the handshake cycle is deferred until gen_done.
                if (gen_ready) begin
                    state_d        = ST_WAIT_DONE;
                    stop_pending_d = ctrl_stop;
                end else if (ctrl_stop) begin
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (ctrl_stop) begin
                    stop_pending_d = 1'b1;
                end
                if (gen_done) begin
                    pkt_inc = 1'b1;
                    pkts_d  = pkts_new;
                    if (stop_pending_q || ctrl_stop ||
                        ((count_q != '0) && (pkts_new == count_q))) begin
                        state_d        = ST_IDLE;
                        stop_pending_d = 1'b0;
                        done_set       = 1'b1;
                    end else if (gap_cfg_q == '0) begin
                        state_d     = ST_LAUNCH;
                        launch_next = 1'b1;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_cfg_q;
                    end
                end
            end
            ST_GAP: begin
                if (ctrl_stop) begin
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                    if (gap_cnt_q <= GAP_ONE) begin
                        state_d     = ST_LAUNCH;
                        launch_next = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch_next) begin
            gen_len_d = len_next;
        end

        if (stat_clear && !pkt_inc) begin
            pkts_d = '0;
        end

        // Setting events take priority over a coincident clear.
        if (done_set) begin
            done_d = 1'b1;
        end else if (stat_clear || start_ok && (state_q == ST_IDLE)) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        if (start_bad && (state_q == ST_IDLE)) begin
            cfg_err_d = 1'b1;
        end else if (stat_clear) begin
            cfg_err_d = 1'b0;
        end else begin
            cfg_err_d = cfg_err_q;
        end

        gen_req_d = (state_d == ST_LAUNCH);
        busy_d    = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            gap_cfg_q      <= '0;
            gap_cnt_q      <= '0;
            stop_pending_q <= 1'b0;
            gen_req_q      <= 1'b0;
            gen_len_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            pkts_q         <= '0;
`ifdef TRAFFIC_GENERATOR_CTRL_LEN_SWEEP_EN
            len_base_q     <= '0;
            len_max_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            gap_cfg_q      <= gap_cfg_d;
            gap_cnt_q      <= gap_cnt_d;
            stop_pending_q <= stop_pending_d;
            gen_req_q      <= gen_req_d;
            gen_len_q      <= gen_len_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
            pkts_q         <= pkts_d;
`ifdef TRAFFIC_GENERATOR_CTRL_LEN_SWEEP_EN
            len_base_q     <= len_base_d;
            len_max_q      <= len_max_d;
`endif
        end
    end

    assign gen_req        = gen_req_q;
    assign gen_len        = gen_len_q;
    assign stat_busy      = busy_q;
    assign stat_done      = done_q;
    assign stat_cfg_err   = cfg_err_q;
    assign stat_pkts_sent = pkts_q;

endmodule

// File: doc/traffic_generator_ctrl.md
Name: traffic_generator_ctrl

Overview:
Run-control sequencer for the traffic generator datapath. It takes start/stop/config values from the CPU register block, launches packets into the generator engine one at a time with a programmable inter-packet gap, counts completed packets, and returns busy/done/error status for CPU readback. It sits between the CPU register block and the packet generation engine, in the register clock domain.

Parameters:
COUNT_WIDTH, 32, width of the packet-count config and the sent counter
GAP_WIDTH, 16, width of the inter-packet gap config, in clock cycles
LEN_WIDTH, 14, width of the packet length, in bytes
MIN_LEN, 60, smallest legal packet length

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESETN  in  1  reset; asynchronous assert, active-low
ctrl_start  in  1  one-cycle start pulse from the register block
ctrl_stop  in  1  one-cycle stop pulse
cfg_pkt_count  in  COUNT_WIDTH  packets per run; 0 = continuous
cfg_gap  in  GAP_WIDTH  idle cycles between packets
cfg_pkt_len  in  LEN_WIDTH  packet length in bytes
gen_req  out  1  packet launch request to the engine
gen_len  out  LEN_WIDTH  length for the launched packet
gen_ready  in  1  engine accepts the request
gen_done  in  1  one-cycle pulse; current packet fully sent
stat_busy  out  1  run in progress
stat_done  out  1  sticky; the last run has ended
stat_cfg_err  out  1  sticky; a start was rejected for bad length
stat_pkts_sent  out  COUNT_WIDTH  packets completed in the current or last run
stat_clear  in  1  clears the sticky flags and the counter

Behaviour:
- Reset (async, S_AXI_ARESETN=0): state=IDLE. All outputs are 0. Latched config, gap counter and stop_pending are 0.
- All outputs are registered.
- Config is latched on an accepted start. cfg_* changes during a run have no effect until the next start.
- IDLE state: stat_busy=0.
  - ctrl_start=1, ctrl_stop=0 and cfg_pkt_len>=MIN_LEN: latch config, stat_pkts_sent<=0, stat_done<=0, go to LAUNCH.
  - ctrl_start with cfg_pkt_len<MIN_LEN: stay in IDLE and set stat_cfg_err.
  - ctrl_start and ctrl_stop in the same cycle: the start is ignored.
- LAUNCH state: gen_req=1 and gen_len=latched length, held stable until gen_ready.
  - gen_req&gen_ready: go to WAIT_DONE; gen_req=0 from the next cycle.
  - ctrl_stop before the handshake: go to IDLE, set stat_done, launch no packet.
- WAIT_DONE state:
  - ctrl_stop sets stop_pending. The current packet always completes.
  - On gen_done, stat_pkts_sent increments, saturating at all-ones.
  - After gen_done, go to IDLE with stat_done=1 if stop_pending, or if cfg_pkt_count!=0 and the new count equals cfg_pkt_count.
  - Otherwise, gen_done with cfg_gap=0 goes to LAUNCH: gen_req is high in cycle T+1, where T is the gen_done cycle.
  - Otherwise, load gap_cnt=cfg_gap and go to GAP.
  - gen_done outside WAIT_DONE is ignored.
- GAP state: gap_cnt decrements each cycle and the block moves to LAUNCH when gap_cnt==1, so gen_req rises in cycle T+1+cfg_gap. ctrl_stop goes to IDLE in the next cycle with stat_done=1.
- stat_busy=1 in LAUNCH, WAIT_DONE and GAP. ctrl_start while busy is ignored.
- stat_clear:
  - Clears stat_done, stat_cfg_err and stat_pkts_sent in any state.
  - If it coincides with an increment, stat_pkts_sent<=1.
  - If it coincides with a rejected start, stat_cfg_err<=1.
  - It does not change state; the count compare then restarts from the cleared value.
- Mid-run reset: immediate return to IDLE, gen_req drops asynchronously, and no stat_done is produced.

Optional Feature:
TRAFFIC_GENERATOR_CTRL_LEN_SWEEP_EN
- Defined: adds input cfg_pkt_len_max (LEN_WIDTH), latched on start.
  - The first packet uses cfg_pkt_len. Each later launch uses previous+1.
  - After reaching cfg_pkt_len_max, the length wraps to cfg_pkt_len.
  - If cfg_pkt_len_max<=cfg_pkt_len, the length stays constant.
  - gen_len updates only on entry to LAUNCH.
- Undefined: the port is absent and gen_len is the constant latched cfg_pkt_len.

Test Plan:
- cfg_pkt_count=3, cfg_gap=4, len=64, engine ready at once, gen_done 10 cycles after accept -> 3 gen_req pulses spaced exactly 4 idle cycles after each gen_done. stat_pkts_sent=3, stat_done=1, stat_busy=0 one cycle after the 3rd gen_done.
- cfg_pkt_count=0, gap=0, stop pulse 2 cycles after the 5th accept -> 5th packet completes, then IDLE. stat_pkts_sent=5, stat_done=1, no 6th gen_req.
- Start with len=59 -> no gen_req, stat_cfg_err=1, stat_busy=0. stat_clear -> stat_cfg_err=0.
- gen_ready held 0 for 20 cycles, then stop -> gen_req stable with gen_len=64 throughout, then IDLE with stat_pkts_sent=0 and stat_done=1.
- stat_clear in the same cycle as the 2nd gen_done of a 4-packet run -> counter=1, and the run ends after 3 more packets with stat_pkts_sent=4.
- S_AXI_ARESETN pulsed low during GAP -> gen_req=0 and every status output 0 immediately, and a new start works normally afterwards. With the _EN macro, len=60 and max=62 -> gen_len sequence 60,61,62,60.
